// File: rtl/carpim_istemci.sv
// Initiator end of the serial multiply link: serializes {a,b} onto tx, then
// deserializes the 2*WIDTH-bit product from rx. Optional check: CARPIM_KONTROL_EN.
module carpim_istemci #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 rx,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [2*WIDTH-1:0]   product
`ifdef CARPIM_KONTROL_EN
  ,
  output logic                 hata
`endif
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(PW + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEND_START = 3'd1,
    SEND_DATA  = 3'd2,
    WAIT_RESP  = 3'd3,
    RECV_DATA  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   tx_sh_q, tx_sh_d;
  logic [PW-1:0]   rx_sh_q, rx_sh_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            tx_d, done_d, timeout_d;
  logic [PW-1:0]   product_d;
  logic            last_bit, wait_expired;

  assign last_bit     = (bit_cnt_q == CW'(PW - 1));
  assign wait_expired = (wait_cnt_q == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (start) state_d = SEND_START;
      SEND_START: state_d = SEND_DATA;
      SEND_DATA:  if (last_bit) state_d = WAIT_RESP;
      WAIT_RESP: begin
        // A start bit arriving on the final wait cycle beats the timeout.
        if (rx)                state_d = RECV_DATA;
        else if (wait_expired) state_d = IDLE;
      end
      RECV_DATA:  if (last_bit) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath/output next values; outputs are registered from these
  always_comb begin
    tx_d       = 1'b0;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    bit_cnt_d  = '0;
    wait_cnt_d = '0;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    product_d  = product;
    case (state_q)
      IDLE: begin
        if (start) begin
          tx_sh_d = {a, b};
          tx_d    = 1'b1;
        end
      end
      SEND_START: begin
        tx_d    = tx_sh_q[PW-1];
        tx_sh_d = tx_sh_q << 1;
      end
      SEND_DATA: begin
        if (!last_bit) begin
          tx_d      = tx_sh_q[PW-1];
          tx_sh_d   = tx_sh_q << 1;
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      WAIT_RESP: begin
        if (rx)                 rx_sh_d    = '0;
        else if (wait_expired)  timeout_d  = 1'b1;
        else                    wait_cnt_d = wait_cnt_q + TW'(1);
      end
      RECV_DATA: begin
        rx_sh_d = {rx_sh_q[PW-2:0], rx};
        if (last_bit) begin
          product_d = {rx_sh_q[PW-2:0], rx};
          done_d    = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      tx         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      product    <= '0;
    end else begin
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      tx         <= tx_d;
      busy       <= (state_d != IDLE);
      done       <= done_d;
      timeout    <= timeout_d;
      product    <= product_d;
    end
  end

`ifdef CARPIM_KONTROL_EN
  logic [PW-1:0] expected_q;

  // Local reference product, compared against the received one on done
  always_ff @(posedge clk) begin
    if (rst) begin
      expected_q <= '0;
      hata       <= 1'b0;
    end else begin
      if (state_q == IDLE && start) expected_q <= PW'(a) * PW'(b);
      if (done_d)         hata <= (product_d != expected_q);
      else if (timeout_d) hata <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_carpim_istemci.sv
// Directed bench for carpim_istemci (WIDTH=3, TIMEOUT=32); acts as the
// multiply unit on rx and checks tx, busy, done, timeout, product (and hata).
module tb_carpim_istemci;

  logic       clk = 1'b0;
  logic       rst, start, rx;
  logic [2:0] a, b;
  logic       tx, busy, done, timeout;
  logic [5:0] product;
`ifdef CARPIM_KONTROL_EN
  logic       hata;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  carpim_istemci #(.WIDTH(3), .TIMEOUT(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .rx      (rx),
    .tx      (tx),
    .busy    (busy),
    .done    (done),
    .timeout (timeout),
    .product (product)
`ifdef CARPIM_KONTROL_EN
    ,
    .hata    (hata)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a request; checks tx over cycles 1..8 (start bit, 6 data bits, idle).
  // With inject set, a second start (a=1,b=1) is pulsed during SEND_DATA.
  task automatic req(input logic [2:0] ta, input logic [2:0] tb_, input logic [6:0] txe,
                     input bit inject);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        chk("busy_cycle1", 32'(busy), 32'd1);
      end
      if (c == 3 && inject) begin
        start = 1'b1; a = 3'd1; b = 3'd1;
      end
      if (c == 4) start = 1'b0;
      chk($sformatf("tx_cycle%0d", c), 32'(tx), 32'(txe[3'(7 - c)]));
    end
    @(negedge clk);
    chk("tx_wait_idle", 32'(tx), 32'd0);
  endtask

  // Reply from WAIT_RESP: start bit now, then 6 bits MSB first; check done cycle.
  task automatic resp(input logic [5:0] bits, input logic [5:0] pexp, input logic hexp);
    rx = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      @(negedge clk);
      rx = bits[i];
      chk("done_early", 32'(done), 32'd0);
    end
    @(negedge clk);
    rx = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("product", 32'(product), 32'(pexp));
    chk("busy_at_done", 32'(busy), 32'd0);
`ifdef CARPIM_KONTROL_EN
    chk("hata", 32'(hata), 32'(hexp));
`else
    if (hexp) ;
`endif
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    rst = 1'b0;

    // 3*5: stream 1,011,101; reply 001111 -> 15
    req(3'd3, 3'd5, 7'b1011101, 1'b0);
    resp(6'b001111, 6'd15, 1'b0);

    // 7*7: stream 1,111,111; reply 110001 -> 49
    req(3'd7, 3'd7, 7'b1111111, 1'b0);
    resp(6'b110001, 6'd49, 1'b0);

    // 2*2 with no reply: WAIT_RESP entered in cycle 8, timeout in cycle 40
    req(3'd2, 3'd2, 7'b1010010, 1'b0);
    for (int c = 9; c <= 39; c++) begin
      @(negedge clk);
      if (c == 39) chk("timeout_early", 32'(timeout), 32'd0);
    end
    @(negedge clk);
    chk("timeout_pulse", 32'(timeout), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_no_done", 32'(done), 32'd0);
    chk("timeout_product_kept", 32'(product), 32'd49);
    @(negedge clk);
    chk("timeout_one_cycle", 32'(timeout), 32'd0);

    // Second start during SEND_DATA must not disturb the stream or queue
    req(3'd3, 3'd5, 7'b1011101, 1'b1);
    resp(6'b001111, 6'd15, 1'b0);
    repeat (3) @(negedge clk);
    chk("no_queued_busy", 32'(busy), 32'd0);
    chk("no_second_done", 32'(done), 32'd0);

    // Wrong reply 14 for 3*5, then a correct one
    req(3'd3, 3'd5, 7'b1011101, 1'b0);
    resp(6'b001110, 6'd14, 1'b1);
    req(3'd3, 3'd5, 7'b1011101, 1'b0);
    resp(6'b001111, 6'd15, 1'b0);

    // Reset after three received data bits
    req(3'd3, 3'd5, 7'b1011101, 1'b0);
    rx = 1'b1;
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    @(negedge clk); rx = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_tx", 32'(tx), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_product", 32'(product), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);

    // Fresh transaction after reset: 6*5 = 30 -> stream 1,110,101; reply 011110
    req(3'd6, 3'd5, 7'b1110101, 1'b0);
    resp(6'b011110, 6'd30, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/carpim_istemci.md
Name: carpim_istemci

Overview:
- Initiator-side peer of the serial multiply unit.
- Accepts two WIDTH-bit operands on a parallel interface, serializes them onto `tx`, then waits for and deserializes the 2*WIDTH-bit product returned on `rx`.
- Used as the host/driver end of the multiply link, wired crosswise (`tx`→unit `rx`, unit `tx`→`rx`).

Parameters:
- WIDTH, 3, bit width of each operand; product is 2*WIDTH bits.
- TIMEOUT, 32, max cycles spent in WAIT_RESP before abort; must be ≥ 1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- rx  input  1  serial line from multiply unit
- tx  output  1  serial line to multiply unit
- busy  output  1  high from cycle after accepted start until return to IDLE
- done  output  1  one-cycle pulse, product valid
- timeout  output  1  one-cycle pulse, no response within TIMEOUT
- product  output  2*WIDTH  last received product, held until next done

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; tx=0, busy=0, done=0, timeout=0, product=0; all counters and shift registers cleared. Reset mid-transfer aborts immediately, with no done/timeout pulse.
- Line format, both directions: idle level 0; one start bit of value 1; then 2*WIDTH data bits, one per clk, MSB first. Outgoing data word is {a,b}, so a[WIDTH-1] is sent first.
- States: IDLE → SEND_START → SEND_DATA → WAIT_RESP → RECV_DATA → IDLE.
- IDLE: tx=0. If start=1, capture {a,b} into the shift register and go to SEND_START. start in any other state is ignored; no queuing.
- SEND_START: tx=1 for exactly one cycle.
- SEND_DATA: tx=shift MSB, shifting left each cycle for 2*WIDTH cycles; bit counter 0..2*WIDTH-1. Then go to WAIT_RESP with tx=0.
- WAIT_RESP:
  - tx=0; wait counter increments each cycle.
  - rx=1 sampled → RECV_DATA, clear bit counter; this sample is the start bit, not data.
  - If the counter reaches TIMEOUT-1 with rx=0 → pulse timeout next cycle and return to IDLE; product is unchanged.
  - If rx=1 and the timeout coincide on the same cycle, the start bit wins.
- RECV_DATA: shift rx into the receive register MSB first for 2*WIDTH cycles. After the last bit, register product, pulse done for one cycle, go to IDLE. rx is ignored outside WAIT_RESP/RECV_DATA.
- Timing, start accepted at edge 0:
  - tx start bit in cycle 1.
  - Data bits in cycles 2..2*WIDTH+1.
  - WAIT_RESP from cycle 2*WIDTH+2.
  - Response start bit sampled at cycle k → data sampled at k+1..k+2*WIDTH; done=1 and product valid in cycle k+2*WIDTH+1.
- busy=0 in the same cycle done or timeout is high; a new start can be accepted in that cycle.
- Bit counters are sized ceil(log2(2*WIDTH+1)); the wait counter is sized for TIMEOUT. Neither wraps: both are cleared on state entry.

Optional Feature:
- Macro: CARPIM_KONTROL_EN.
- With it defined:
  - Extra output port `hata` (1 bit), reset 0.
  - On the captured operands the block computes a*b (2*WIDTH-bit unsigned) and holds the result.
  - In the done cycle, hata = (received product != a*b). hata is held until the next done, a timeout (cleared to 0), or reset.
- Without it: no `hata` port and no multiplier logic; all other behaviour is identical.

Test Plan:
- Basic multiply, WIDTH=3: a=3, b=5, start → tx cycles 1..7 = 1,0,1,1,1,0,1. Bench returns rx=1 then 0,0,1,1,1,1 → done pulse, product=15, busy falls the same cycle.
- Max operands: a=7, b=7 → tx data 111111. Reply 110001 → product=49. With CARPIM_KONTROL_EN, hata=0.
- Timeout: a=2, b=2, rx held 0 → timeout pulses exactly TIMEOUT cycles after WAIT_RESP entry. product keeps its previous value (49); no done.
- Start ignored while busy: assert start with a=1, b=1 during SEND_DATA → tx serial stream unchanged from the first request; only one done.
- Reset mid-operation: rst in RECV_DATA after 3 bits → next cycle tx=0, busy=0, product=0. A fresh start then completes normally.
- Mismatch (CARPIM_KONTROL_EN): a=3, b=5, reply product 14 → done with product=14 and hata=1. A following correct transaction clears hata to 0.
